// File: rtl/shared_datamem.sv
// Shared word-addressed data memory: round-robin arbitration over CORES request ports, one access per cycle.
// Optional DM_LOCK_EN adds a per-core lock input that pins the arbiter to one owner for atomic read-modify-write.
module shared_datamem #(
  parameter int CORES      = 4,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [CORES-1:0]      req,
  input  logic [CORES-1:0]      we,
  input  logic [32*CORES-1:0]   addr,
  input  logic [32*CORES-1:0]   wdata,
`ifdef DM_LOCK_EN
  input  logic [CORES-1:0]      lock,
`endif
  output logic [CORES-1:0]      ack,
  output logic [31:0]           rdata
);

  localparam int PTR_W = (CORES > 1) ? $clog2(CORES) : 1;
  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [31:0]           memory [DEPTH];
  logic [PTR_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic [CORES-1:0]      ack_q, ack_d;
  logic [31:0]           rdata_q, rdata_d;
  logic [CORES-1:0]      elig;
  logic                  gnt_valid;
  logic [PTR_W-1:0]      gnt_idx;
  logic [31:0]           addr_g, wdata_g;
  logic                  we_g, in_range, mem_wr;
  logic [ADDR_WIDTH-1:0] word_idx;

`ifdef DM_LOCK_EN
  logic                  lock_valid_q, lock_valid_d;
  logic [PTR_W-1:0]      lock_owner_q, lock_owner_d;

  always_comb begin
    elig = req;
    if (lock_valid_q) elig = req & (CORES'(1) << lock_owner_q);
  end
`else
  always_comb elig = req;
`endif

  // Scan in reverse so the core nearest rr_ptr in search order is the last (winning) assignment.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    for (int k = CORES - 1; k >= 0; k--) begin
      if (elig[(int'(rr_ptr_q) + k) % CORES]) begin
        gnt_valid = 1'b1;
        gnt_idx   = PTR_W'((int'(rr_ptr_q) + k) % CORES);
      end
    end
  end

  always_comb begin
    addr_g   = addr[32*int'(gnt_idx) +: 32];
    wdata_g  = wdata[32*int'(gnt_idx) +: 32];
    we_g     = we[gnt_idx];
    in_range = (addr_g >> (ADDR_WIDTH + 2)) == 32'd0;
    word_idx = addr_g[ADDR_WIDTH+1:2];
    mem_wr   = gnt_valid && we_g && in_range && !reset;
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    ack_d    = '0;
    rdata_d  = rdata_q;
    if (gnt_valid) begin
      rr_ptr_d = (int'(gnt_idx) == CORES - 1) ? '0 : gnt_idx + PTR_W'(1);
      ack_d    = CORES'(1) << gnt_idx;
      if (!we_g) rdata_d = in_range ? memory[word_idx] : 32'd0;
    end
  end

`ifdef DM_LOCK_EN
  // The owner's first unlocked access is the one that releases the lock.
  always_comb begin
    lock_valid_d = lock_valid_q;
    lock_owner_d = lock_owner_q;
    if (gnt_valid) begin
      if (lock[gnt_idx]) begin
        lock_valid_d = 1'b1;
        lock_owner_d = gnt_idx;
      end else if (lock_valid_q) begin
        lock_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lock_valid_q <= 1'b0;
      lock_owner_q <= '0;
    end else begin
      lock_valid_q <= lock_valid_d;
      lock_owner_q <= lock_owner_d;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr_q <= '0;
      ack_q    <= '0;
      rdata_q  <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      ack_q    <= ack_d;
      rdata_q  <= rdata_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_wr) memory[word_idx] <= wdata_g;
  end

  assign ack   = ack_q;
  assign rdata = rdata_q;

endmodule

// File: tb/tb_shared_datamem.sv
// Directed bench for shared_datamem (CORES=4, ADDR_WIDTH=10); the lock scenario runs when DM_LOCK_EN is defined.
module tb_shared_datamem;
  localparam int CORES = 4;

  logic                clk = 1'b0;
  logic                reset;
  logic [CORES-1:0]    req, we;
  logic [32*CORES-1:0] addr, wdata;
  logic [CORES-1:0]    ack;
  logic [31:0]         rdata;
`ifdef DM_LOCK_EN
  logic [CORES-1:0]    lock;
`endif

  int errors = 0;
  int checks = 0;

  shared_datamem #(.CORES(CORES), .ADDR_WIDTH(10)) dut (
    .clk   (clk),
    .reset (reset),
    .req   (req),
    .we    (we),
    .addr  (addr),
    .wdata (wdata),
`ifdef DM_LOCK_EN
    .lock  (lock),
`endif
    .ack   (ack),
    .rdata (rdata)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int c, input logic r, input logic w,
                       input logic [31:0] a, input logic [31:0] d);
    req[c]            = r;
    we[c]             = w;
    addr[32*c +: 32]  = a;
    wdata[32*c +: 32] = d;
  endtask

  task automatic store0(input logic [31:0] a, input logic [31:0] d);
    drive(0, 1'b1, 1'b1, a, d);
    tick();
    chk("preload_ack", 32'(ack), 32'h1);
    req[0] = 1'b0;
  endtask

  logic [3:0] rr_exp [6] = '{4'b0010, 4'b1000, 4'b0010, 4'b1000, 4'b0010, 4'b1000};
  logic [31:0] rr_dat [6] = '{32'd14, 32'd12, 32'd14, 32'd12, 32'd14, 32'd12};

  initial begin
    reset = 1'b1;
    req = '0; we = '0; addr = '0; wdata = '0;
`ifdef DM_LOCK_EN
    lock = '0;
`endif
    tick(); tick();
    reset = 1'b0;
    chk("reset_ack", 32'(ack), 32'h0);
    chk("reset_rdata", rdata, 32'h0);
    chk("reset_ptr", 32'(dut.rr_ptr_q), 32'h0);

    // single core store then load
    drive(0, 1'b1, 1'b1, 32'h8, 32'd14);
    tick();
    chk("st_ack", 32'(ack), 32'h1);
    chk("st_mem2", dut.memory[2], 32'd14);
    we[0] = 1'b0;
    tick();
    chk("ld_ack", 32'(ack), 32'h1);
    chk("ld_rdata", rdata, 32'd14);
    req[0] = 1'b0;
    tick();
    chk("idle_ack", 32'(ack), 32'h0);

    store0(32'h0, 32'd14);
    store0(32'h4, 32'd12);
    store0(32'h8, 32'd13);
    store0(32'hC, 32'd5);
    store0(32'h10, 32'd9);
    store0(32'h14, 32'd77);
    reset = 1'b1;
    tick();
    reset = 1'b0;

    // all four cores load in the same cycle
    for (int c = 0; c < CORES; c++) drive(c, 1'b1, 1'b0, 32'(4*c), 32'h0);
    tick(); chk("all_ack0", 32'(ack), 32'h1); chk("all_rd0", rdata, 32'd14); req[0] = 1'b0;
    tick(); chk("all_ack1", 32'(ack), 32'h2); chk("all_rd1", rdata, 32'd12); req[1] = 1'b0;
    tick(); chk("all_ack2", 32'(ack), 32'h4); chk("all_rd2", rdata, 32'd13); req[2] = 1'b0;
    tick(); chk("all_ack3", 32'(ack), 32'h8); chk("all_rd3", rdata, 32'd5);  req[3] = 1'b0;

    // cores 1 and 3 hold req: grants alternate
    drive(1, 1'b1, 1'b0, 32'h0, 32'h0);
    drive(3, 1'b1, 1'b0, 32'h4, 32'h0);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk($sformatf("rr_ack%0d", i), 32'(ack), 32'(rr_exp[i]));
      chk($sformatf("rr_rd%0d", i), rdata, rr_dat[i]);
    end
    req = '0;
    tick();
    chk("rr_idle", 32'(ack), 32'h0);

    // out-of-range aliases word 0 in the low bits but must not touch it
    drive(2, 1'b1, 1'b0, 32'h0001_0000, 32'h0);
    tick();
    chk("oor_ld_ack", 32'(ack), 32'h4);
    chk("oor_ld_rdata", rdata, 32'h0);
    drive(2, 1'b1, 1'b1, 32'h0001_0000, 32'hDEAD_BEEF);
    tick();
    chk("oor_st_ack", 32'(ack), 32'h4);
    req = '0;
    tick();
    chk("oor_mem0", dut.memory[0], 32'd14);
    chk("oor_mem1", dut.memory[1], 32'd12);
    chk("oor_mem5", dut.memory[5], 32'd77);

    // reset during core 2's store grant
    drive(2, 1'b1, 1'b1, 32'h14, 32'h55);
    reset = 1'b1;
    tick();
    chk("rst_ack", 32'(ack), 32'h0);
    chk("rst_mem5", dut.memory[5], 32'd77);
    chk("rst_ptr", 32'(dut.rr_ptr_q), 32'h0);
    reset = 1'b0;
    we[2] = 1'b0;
    tick();
    chk("post_rst_ack", 32'(ack), 32'h4);
    chk("post_rst_rdata", rdata, 32'd77);
    req = '0;
    tick();

`ifdef DM_LOCK_EN
    drive(1, 1'b1, 1'b0, 32'h10, 32'h0);
    lock[1] = 1'b1;
    tick();
    chk("lk_ld_ack", 32'(ack), 32'h2);
    chk("lk_ld_rdata", rdata, 32'd9);
    req[1] = 1'b0;
    lock[1] = 1'b0;
    drive(0, 1'b1, 1'b0, 32'h10, 32'h0);
    tick(); chk("lk_block0", 32'(ack), 32'h0);
    tick(); chk("lk_block1", 32'(ack), 32'h0);
    drive(1, 1'b1, 1'b1, 32'h10, 32'd10);
    tick();
    chk("lk_st_ack", 32'(ack), 32'h2);
    chk("lk_mem4", dut.memory[4], 32'd10);
    req[1] = 1'b0;
    tick();
    chk("lk_c0_ack", 32'(ack), 32'h1);
    chk("lk_c0_rdata", rdata, 32'd10);
    req = '0;
    tick();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
